// File: rtl/mem_access_controller.sv
// -----------------------------------------------------------------------------
// mem_access_controller
//
// Memory-stage access sequencer between the processor datapath and RAM1.
// A request is sampled only in IDLE, where address, data and direction are
// latched. The access then runs in ACCESS until the RAM raises MFC or the wait
// counter expires, and completes with a one-cycle Ack in DONE.
//
// Ports
//   Clock                rising-edge clock for all state
//   Reset                synchronous active-high reset
//   Req                  access request (level), sampled only in IDLE
//   Req_Write            1 = write, 0 = read
//   Req_Address          word address from MuxMA
//   Req_Data             write data from RM
//   Err_Clear            clears the sticky Timeout_Err flag
//   RAM1_Data_Out        RAM read data
//   RAM1_MFC             RAM memory-function-complete
//   RAM1_Address         RAM word address (latched)
//   RAM1_Data_In         RAM write data (latched)
//   RAM1_Read_H_Write_L  1 = read, 0 = write; forced to 1 outside ACCESS
//   RAM1_Strobe          high for the whole ACCESS phase
//   Stall                holds the stage sequencer during ACCESS
//   Ack                  one-cycle completion pulse (DONE)
//   Rd_Data              captured read data, feeds MuxY
//   Timeout_Err          sticky timeout flag, feeds the CCR
//   Access_Count         number of completed accesses, wraps at 16 bits
// -----------------------------------------------------------------------------
module mem_access_controller #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Req,
    input  logic                  Req_Write,
    input  logic [DATA_WIDTH-1:0] Req_Address,
    input  logic [DATA_WIDTH-1:0] Req_Data,
    input  logic                  Err_Clear,
    input  logic [DATA_WIDTH-1:0] RAM1_Data_Out,
    input  logic                  RAM1_MFC,
    output logic [DATA_WIDTH-1:0] RAM1_Address,
    output logic [DATA_WIDTH-1:0] RAM1_Data_In,
    output logic                  RAM1_Read_H_Write_L,
    output logic                  RAM1_Strobe,
    output logic                  Stall,
    output logic                  Ack,
    output logic [DATA_WIDTH-1:0] Rd_Data,
    output logic                  Timeout_Err,
    output logic [15:0]           Access_Count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Last wait-counter value before the access is abandoned.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                state;
    state_t                next_state;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [7:0]            wait_cnt;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  timeout_err_q;
    logic [15:0]           count_q;

    logic                  start;
    logic                  mfc_done;
    logic                  timeout_hit;

    // MFC wins over an expiring counter in the same cycle.
    assign start       = (state == IDLE) && Req;
    assign mfc_done    = (state == ACCESS) && RAM1_MFC;
    assign timeout_hit = (state == ACCESS) && !RAM1_MFC && (wait_cnt == TIMEOUT_LAST);

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and outputs
    always_comb begin
        next_state          = state;
        RAM1_Strobe         = 1'b0;
        Stall               = 1'b0;
        RAM1_Read_H_Write_L = 1'b1;
        Ack                 = 1'b0;
        case (state)
            IDLE: begin
                if (Req) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                RAM1_Strobe         = 1'b1;
                Stall               = 1'b1;
                RAM1_Read_H_Write_L = ~wr_q;
                if (mfc_done || timeout_hit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                Ack        = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request latches, wait counter, read capture and completion counter
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            wait_cnt  <= '0;
            rd_data_q <= '0;
            count_q   <= '0;
        end else begin
            if (start) begin
                wr_q     <= Req_Write;
                addr_q   <= Req_Address;
                data_q   <= Req_Data;
                wait_cnt <= '0;
            end
            if ((state == ACCESS) && !RAM1_MFC) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (mfc_done && !wr_q) begin
                rd_data_q <= RAM1_Data_Out;
            end else if (timeout_hit && !wr_q) begin
                rd_data_q <= '0;
            end
            if (state == DONE) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    // Sticky error: a new timeout beats a simultaneous clear.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            timeout_err_q <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err_q <= 1'b1;
        end else if (Err_Clear) begin
            timeout_err_q <= 1'b0;
        end
    end

    assign RAM1_Address = addr_q;
    assign RAM1_Data_In = data_q;
    assign Rd_Data      = rd_data_q;
    assign Timeout_Err  = timeout_err_q;
    assign Access_Count = count_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// -----------------------------------------------------------------------------
// tb_mem_access_controller
//
// Self-checking bench for mem_access_controller: a per-cycle vector table for
// the basic read/write/ignored-request flows, then hand-written sequences for
// timeout, MFC-at-deadline, timeout vs. Err_Clear, reset mid-access and
// counter wrap with back-to-back requests.
// -----------------------------------------------------------------------------
module tb_mem_access_controller;

    logic        Clock;
    logic        Reset;
    logic        Req;
    logic        Req_Write;
    logic [31:0] Req_Address;
    logic [31:0] Req_Data;
    logic        Err_Clear;
    logic [31:0] RAM1_Data_Out;
    logic        RAM1_MFC;
    logic [31:0] RAM1_Address;
    logic [31:0] RAM1_Data_In;
    logic        RAM1_Read_H_Write_L;
    logic        RAM1_Strobe;
    logic        Stall;
    logic        Ack;
    logic [31:0] Rd_Data;
    logic        Timeout_Err;
    logic [15:0] Access_Count;

    int checks = 0;
    int fails  = 0;

    mem_access_controller #(
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .Req                (Req),
        .Req_Write          (Req_Write),
        .Req_Address        (Req_Address),
        .Req_Data           (Req_Data),
        .Err_Clear          (Err_Clear),
        .RAM1_Data_Out      (RAM1_Data_Out),
        .RAM1_MFC           (RAM1_MFC),
        .RAM1_Address       (RAM1_Address),
        .RAM1_Data_In       (RAM1_Data_In),
        .RAM1_Read_H_Write_L(RAM1_Read_H_Write_L),
        .RAM1_Strobe        (RAM1_Strobe),
        .Stall              (Stall),
        .Ack                (Ack),
        .Rd_Data            (Rd_Data),
        .Timeout_Err        (Timeout_Err),
        .Access_Count       (Access_Count)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        logic        req;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic        mfc;
        logic [31:0] ram;
        logic        exp_strobe;
        logic        exp_rhwl;
        logic        exp_ack;
        logic [31:0] exp_addr;
        logic [31:0] exp_din;
        logic [31:0] exp_rd;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    // Run one access; MFC is raised in ACCESS cycle mfc_cycle (0 = never) and
    // Err_Clear in ACCESS cycle clr_cycle (0 = never). Returns the number of
    // ACCESS cycles seen; leaves the DUT in DONE.
    task automatic do_access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                             input int mfc_cycle, input logic [31:0] ram, input int clr_cycle,
                             output int n);
        Req         = 1'b1;
        Req_Write   = wr;
        Req_Address = addr;
        Req_Data    = data;
        RAM1_MFC    = 1'b0;
        cyc();
        Req = 1'b0;
        n   = 0;
        while (Stall && n < 40) begin
            n++;
            RAM1_MFC      = (n == mfc_cycle);
            RAM1_Data_Out = ram;
            Err_Clear     = (n == clr_cycle);
            cyc();
        end
        RAM1_MFC  = 1'b0;
        Err_Clear = 1'b0;
    endtask

    initial begin
        int          n;
        logic        wrap_strobe[6];
        logic        wrap_ack[6];
        logic [15:0] wrap_cnt[6];

        //            req wr  addr        data          mfc  ram           stb  rhwl ack  addr        din           rd            cnt
        vecs[0]  = '{1'b1, 1'b0, 32'h10, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h10, 32'h0,        32'h0,        16'd0};
        vecs[1]  = '{1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h10, 32'h0,        32'h0,        16'd0};
        vecs[2]  = '{1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h10, 32'h0,        32'h0,        16'd0};
        vecs[3]  = '{1'b0, 1'b0, 32'h10, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0,        32'hCAFEF00D, 16'd0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h10, 32'h0,        32'hCAFEF00D, 16'd1};
        vecs[5]  = '{1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h20, 32'h12345678, 32'hCAFEF00D, 16'd1};
        vecs[6]  = '{1'b0, 1'b1, 32'h20, 32'h12345678, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 32'h20, 32'h12345678, 32'hCAFEF00D, 16'd1};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h20, 32'h12345678, 32'hCAFEF00D, 16'd2};
        vecs[8]  = '{1'b1, 1'b0, 32'h30, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h30, 32'h0,        32'hCAFEF00D, 16'd2};
        vecs[9]  = '{1'b1, 1'b0, 32'h44, 32'h0,        1'b1, 32'h5555AAAA, 1'b0, 1'b1, 1'b1, 32'h30, 32'h0,        32'h5555AAAA, 16'd2};
        vecs[10] = '{1'b1, 1'b0, 32'h44, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h30, 32'h0,        32'h5555AAAA, 16'd3};
        vecs[11] = '{1'b1, 1'b1, 32'h44, 32'hA5A5,     1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h44, 32'hA5A5,     32'h5555AAAA, 16'd3};
        vecs[12] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'h77777777, 1'b0, 1'b1, 1'b1, 32'h44, 32'hA5A5,     32'h5555AAAA, 16'd3};
        vecs[13] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h44, 32'hA5A5,     32'h5555AAAA, 16'd4};

        Reset = 1'b1; Req = 1'b0; Req_Write = 1'b0; Req_Address = '0; Req_Data = '0;
        Err_Clear = 1'b0; RAM1_Data_Out = '0; RAM1_MFC = 1'b0;
        cyc();
        cyc();
        Reset = 1'b0;

        // Reset state
        check("rst_strobe", 32'(RAM1_Strobe), 32'd0);
        check("rst_stall",  32'(Stall), 32'd0);
        check("rst_rhwl",   32'(RAM1_Read_H_Write_L), 32'd1);
        check("rst_ack",    32'(Ack), 32'd0);
        check("rst_rd",     Rd_Data, 32'd0);
        check("rst_err",    32'(Timeout_Err), 32'd0);
        check("rst_cnt",    32'(Access_Count), 32'd0);
        check("rst_addr",   RAM1_Address, 32'd0);

        // Read, write, and requests ignored outside IDLE
        for (int i = 0; i < 14; i++) begin
            Req           = vecs[i].req;
            Req_Write     = vecs[i].wr;
            Req_Address   = vecs[i].addr;
            Req_Data      = vecs[i].data;
            RAM1_MFC      = vecs[i].mfc;
            RAM1_Data_Out = vecs[i].ram;
            cyc();
            check($sformatf("v%0d_strobe", i), 32'(RAM1_Strobe), 32'(vecs[i].exp_strobe));
            check($sformatf("v%0d_stall", i),  32'(Stall), 32'(vecs[i].exp_strobe));
            check($sformatf("v%0d_rhwl", i),   32'(RAM1_Read_H_Write_L), 32'(vecs[i].exp_rhwl));
            check($sformatf("v%0d_ack", i),    32'(Ack), 32'(vecs[i].exp_ack));
            check($sformatf("v%0d_addr", i),   RAM1_Address, vecs[i].exp_addr);
            check($sformatf("v%0d_din", i),    RAM1_Data_In, vecs[i].exp_din);
            check($sformatf("v%0d_rd", i),     Rd_Data, vecs[i].exp_rd);
            check($sformatf("v%0d_err", i),    32'(Timeout_Err), 32'd0);
            check($sformatf("v%0d_cnt", i),    32'(Access_Count), 32'(vecs[i].exp_cnt));
        end
        Req = 1'b0; RAM1_MFC = 1'b0;

        // Timeout on a read, then Err_Clear
        do_access(1'b0, 32'h50, 32'h0, 0, 32'h99, 0, n);
        check("to_cycles", 32'(n), 32'd15);
        check("to_ack",    32'(Ack), 32'd1);
        check("to_rd",     Rd_Data, 32'd0);
        check("to_err",    32'(Timeout_Err), 32'd1);
        Err_Clear = 1'b1;
        cyc();
        Err_Clear = 1'b0;
        check("to_clr_err", 32'(Timeout_Err), 32'd0);
        check("to_cnt",     32'(Access_Count), 32'd5);
        check("to_idle_ack", 32'(Ack), 32'd0);

        // MFC exactly in the last allowed cycle completes normally
        do_access(1'b0, 32'h60, 32'h0, 15, 32'h0BADCAFE, 0, n);
        check("edge_cycles", 32'(n), 32'd15);
        check("edge_ack",    32'(Ack), 32'd1);
        check("edge_rd",     Rd_Data, 32'h0BADCAFE);
        check("edge_err",    32'(Timeout_Err), 32'd0);
        cyc();
        check("edge_cnt",    32'(Access_Count), 32'd6);

        // Timeout in the same cycle as Err_Clear: set wins
        do_access(1'b0, 32'h70, 32'h0, 0, 32'h0, 15, n);
        check("toclr_cycles", 32'(n), 32'd15);
        check("toclr_err",    32'(Timeout_Err), 32'd1);
        check("toclr_rd",     Rd_Data, 32'd0);
        cyc();
        check("toclr_hold",   32'(Timeout_Err), 32'd1);
        Err_Clear = 1'b1;
        cyc();
        Err_Clear = 1'b0;
        check("toclr_clear",  32'(Timeout_Err), 32'd0);

        // Reset in the 2nd ACCESS cycle with Req held
        Req = 1'b1; Req_Write = 1'b0; Req_Address = 32'h80; RAM1_MFC = 1'b0;
        cyc();
        check("rma_access", 32'(RAM1_Strobe), 32'd1);
        cyc();
        check("rma_access2", 32'(RAM1_Strobe), 32'd1);
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        check("rma_strobe", 32'(RAM1_Strobe), 32'd0);
        check("rma_ack",    32'(Ack), 32'd0);
        check("rma_cnt",    32'(Access_Count), 32'd0);
        check("rma_err",    32'(Timeout_Err), 32'd0);
        check("rma_addr",   RAM1_Address, 32'd0);
        check("rma_rd",     Rd_Data, 32'd0);
        cyc();
        check("rma_restart", 32'(RAM1_Strobe), 32'd1);
        check("rma_raddr",   RAM1_Address, 32'h80);
        Req = 1'b0; RAM1_MFC = 1'b1; RAM1_Data_Out = 32'h13579BDF;
        cyc();
        RAM1_MFC = 1'b0;
        check("rma_ack2", 32'(Ack), 32'd1);
        check("rma_rd2",  Rd_Data, 32'h13579BDF);
        cyc();
        check("rma_cnt2", 32'(Access_Count), 32'd1);

        // Jump the counter near its wrap point, then hold Req with MFC ready.
        dut.count_q = 16'hFFFE;
        wrap_strobe = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        wrap_ack    = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        wrap_cnt    = '{16'hFFFE, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
        Req = 1'b1; Req_Write = 1'b0; Req_Address = 32'h90; RAM1_MFC = 1'b1; RAM1_Data_Out = 32'h2468ACE0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check($sformatf("wrap%0d_strobe", i), 32'(RAM1_Strobe), 32'(wrap_strobe[i]));
            check($sformatf("wrap%0d_ack", i),    32'(Ack), 32'(wrap_ack[i]));
            check($sformatf("wrap%0d_cnt", i),    32'(Access_Count), 32'(wrap_cnt[i]));
        end
        Req = 1'b0; RAM1_MFC = 1'b0;
        check("wrap_rd", Rd_Data, 32'h2468ACE0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
